// File: rtl/sim_watchdog_pkg.sv
// ---------------------------------------------------------------------------
// sim_watchdog_pkg
//
// Shared definitions for the multi-core commit watchdog:
//   wd_state_e    : per-core watchdog state (IDLE / ARMED / TIMEOUT)
//   DEFAULT_LIMIT : stuck limit loaded into the shared limit register and
//                   every per-core counter when reset_n is low
// ---------------------------------------------------------------------------
package sim_watchdog_pkg;

    // IDLE    : core has not committed yet, nothing to watch
    // ARMED   : core has committed at least once, counter runs down
    // TIMEOUT : counter ran out without a commit, sticky until clear/reset
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TIMEOUT = 2'd2
    } wd_state_e;

    localparam longint unsigned DEFAULT_LIMIT = 64'd15000;

endpackage : sim_watchdog_pkg

// File: rtl/sim_watchdog_chan.sv
// ---------------------------------------------------------------------------
// sim_watchdog_chan
//
// Watchdog state machine and down-counter for a single commit stream.
//
// Parameters:
//   CNT_W       : counter / limit width
//   RESET_VALUE : counter value while reset_n is low
//
// Ports:
//   clock         in   rising-edge clock
//   reset_n       in   synchronous active-low reset
//   valid         in   commit seen on this core this cycle
//   limit         in   current shared stuck limit (0 disables detection)
//   load          in   shared limit is being rewritten this cycle
//   load_value    in   value being written into the shared limit
//   clear         in   return to IDLE, drop any timeout
//   timeout       out  core is in TIMEOUT (sticky)
//   armed         out  core is in ARMED
//   timeout_pulse out  this edge moves ARMED -> TIMEOUT (used for reporting)
// ---------------------------------------------------------------------------
module sim_watchdog_chan
    import sim_watchdog_pkg::*;
#(
    parameter int unsigned      CNT_W       = 64,
    parameter logic [CNT_W-1:0] RESET_VALUE = CNT_W'(DEFAULT_LIMIT)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [CNT_W-1:0] limit,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             clear,
    output logic             timeout,
    output logic             armed,
    output logic             timeout_pulse
);

    wd_state_e        state;
    wd_state_e        state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] window;

    // Value the shared limit register holds after this edge; any reload that
    // happens in the same cycle as a limit write must pick up the new value.
    assign window = load ? load_value : limit;

    // State and counter registers, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= RESET_VALUE;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state and next-count decision.  Clear beats everything.  In ARMED
    // a limit write restarts the window, a commit reloads it, and only when
    // neither happens does the counter run down; reaching zero without a
    // commit is what trips the timeout, so a commit at zero still rescues the
    // core.  A zero limit freezes the counter so no timeout is ever raised.
    always_comb begin
        state_next = state;
        count_next = count;
        if (clear) begin
            state_next = IDLE;
            count_next = window;
        end else begin
            unique case (state)
                IDLE: begin
                    count_next = window;
                    if (valid) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (load || valid) begin
                        count_next = window;
                    end else if (limit == '0) begin
                        count_next = count;
                    end else if (count == '0) begin
                        state_next = TIMEOUT;
                    end else begin
                        count_next = count - CNT_W'(1);
                    end
                end
                TIMEOUT: begin
                    count_next = '0;
                end
                default: begin
                    state_next = IDLE;
                    count_next = window;
                end
            endcase
        end
    end

    // Status outputs decode the state register; the pulse looks one edge
    // ahead so the top can report on the very edge the timeout is taken.
    always_comb begin
        timeout       = (state == TIMEOUT);
        armed         = (state == ARMED);
        timeout_pulse = reset_n && (state == ARMED) && (state_next == TIMEOUT);
    end

endmodule : sim_watchdog_chan

// File: rtl/sim_watchdog_mc.sv
// ---------------------------------------------------------------------------
// sim_watchdog_mc
//
// Multi-core commit watchdog for simulation top levels.  Each core that has
// committed at least once is watched; if it then goes longer than the shared
// limit without a commit its sticky timeout flag is raised, a message is
// printed and (optionally) the simulation is ended.
//
// Parameters:
//   NUM_CORES         : number of monitored commit channels (1..64)
//   CNT_W             : width of the stuck limit and per-core counters
//   DEFAULT_LIMIT     : stuck limit loaded at reset
//   FINISH_ON_TIMEOUT : 1 = end simulation on first timeout, 0 = report only
//
// Ports:
//   clock          in   clock, all logic on rising edge
//   reset_n        in   synchronous active-low reset
//   io_valid       in   per-core commit valid, bit i = core i
//   io_limit       in   new stuck limit
//   io_limit_load  in   write io_limit into the limit register
//   io_clear       in   drop all timeouts, return every core to IDLE
//   io_timeout     out  sticky per-core timeout flags
//   io_timeout_any out  OR of io_timeout
//   io_stuck_core  out  lowest core index with a timeout (0 when none)
//   io_armed       out  core has committed and is being watched
// ---------------------------------------------------------------------------
module sim_watchdog_mc #(
    parameter int unsigned      NUM_CORES         = 1,
    parameter int unsigned      CNT_W             = 64,
    parameter logic [CNT_W-1:0] DEFAULT_LIMIT     = CNT_W'(sim_watchdog_pkg::DEFAULT_LIMIT),
    parameter bit               FINISH_ON_TIMEOUT = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_CORES-1:0]         io_valid,
    input  logic [CNT_W-1:0]             io_limit,
    input  logic                         io_limit_load,
    input  logic                         io_clear,
    output logic [NUM_CORES-1:0]         io_timeout,
    output logic                         io_timeout_any,
    output logic [$clog2(NUM_CORES):0]   io_stuck_core,
    output logic [NUM_CORES-1:0]         io_armed
);

    localparam int unsigned SW = $clog2(NUM_CORES) + 1;

    logic [CNT_W-1:0]     limit;
    logic [NUM_CORES-1:0] timeout_pulse;

    // Shared stuck limit.  A write becomes visible to the channels' decisions
    // from the following edge; on the write edge itself the channels reload
    // directly from io_limit.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            limit <= DEFAULT_LIMIT;
        end else if (io_limit_load) begin
            limit <= io_limit;
        end
    end

    // One independent watchdog channel per monitored core.
    for (genvar g = 0; g < NUM_CORES; g++) begin : g_chan
        sim_watchdog_chan #(
            .CNT_W       (CNT_W),
            .RESET_VALUE (DEFAULT_LIMIT)
        ) u_chan (
            .clock         (clock),
            .reset_n       (reset_n),
            .valid         (io_valid[g]),
            .limit         (limit),
            .load          (io_limit_load),
            .load_value    (io_limit),
            .clear         (io_clear),
            .timeout       (io_timeout[g]),
            .armed         (io_armed[g]),
            .timeout_pulse (timeout_pulse[g])
        );
    end

    // Summary flag and lowest-index priority encoder over the sticky flags.
    // Scanning from the top down lets the lowest set index win.
    always_comb begin
        io_timeout_any = |io_timeout;
        io_stuck_core  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (io_timeout[i]) begin
                io_stuck_core = SW'(i);
            end
        end
    end

    // Diagnostic reporting on the edge each core enters TIMEOUT.  Every core
    // that trips on the same edge gets its own line before the run is ended.
    always @(posedge clock) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (timeout_pulse[i]) begin
                $display("Core %0d has no commit for %0d cycles", i, limit);
            end
        end
        if (FINISH_ON_TIMEOUT && (|timeout_pulse)) begin
            $finish;
        end
    end

endmodule : sim_watchdog_mc

// File: tb/tb_sim_watchdog_mc.sv
// ---------------------------------------------------------------------------
// tb_sim_watchdog_mc
//
// Directed bench for a two-core watchdog in report-only mode.  Stimulus
// pushes hand-computed expected outputs, tagged with the edge after which
// they must hold, into a scoreboard queue; a monitor running on the falling
// edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_sim_watchdog_mc;

    localparam int NC = 2;
    localparam int CW = 16;
    localparam int SW = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [NC-1:0] io_valid;
    logic [CW-1:0] io_limit;
    logic          io_limit_load;
    logic          io_clear;
    logic [NC-1:0] io_timeout;
    logic          io_timeout_any;
    logic [SW-1:0] io_stuck_core;
    logic [NC-1:0] io_armed;

    typedef struct {
        string         name;
        int            at;
        logic [NC-1:0] to;
        logic [NC-1:0] armed;
        logic [SW-1:0] stuck;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    sim_watchdog_mc #(
        .NUM_CORES         (NC),
        .CNT_W             (CW),
        .DEFAULT_LIMIT     (16'd15000),
        .FINISH_ON_TIMEOUT (1'b0)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .io_valid       (io_valid),
        .io_limit       (io_limit),
        .io_limit_load  (io_limit_load),
        .io_clear       (io_clear),
        .io_timeout     (io_timeout),
        .io_timeout_any (io_timeout_any),
        .io_stuck_core  (io_stuck_core),
        .io_armed       (io_armed)
    );

    // 10-unit clock period.
    always #5 clock = ~clock;

    // Edge counter: after rising edge n, cyc == n.
    always @(posedge clock) cyc <= cyc + 1;

    // Queue an expectation that must hold after the edge 'delay' edges from now.
    task automatic checkOutput(input string name, input int delay,
                               input logic [NC-1:0] to, input logic [NC-1:0] armed,
                               input logic [SW-1:0] stuck);
        exp_t e;
        e.name  = name;
        e.at    = cyc + delay;
        e.to    = to;
        e.armed = armed;
        e.stuck = stuck;
        sb.push_back(e);
    endtask

    // Present one cycle of inputs, let one rising edge sample them, then idle.
    task automatic applyStimulus(input logic [NC-1:0] v, input logic ld,
                                 input logic [CW-1:0] lim, input logic clr);
        io_valid      = v;
        io_limit_load = ld;
        io_limit      = lim;
        io_clear      = clr;
        @(posedge clock);
        #1;
        io_valid      = '0;
        io_limit_load = 1'b0;
        io_clear      = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: compare every expectation that has come due on this falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.at < cyc) begin
                    n_errors++;
                    $display("[TB] FAIL %s: not sampled at edge %0d (now %0d)", e.name, e.at, cyc);
                end else if (io_timeout !== e.to || io_armed !== e.armed ||
                             io_stuck_core !== e.stuck || io_timeout_any !== (|e.to)) begin
                    n_errors++;
                    $display("[TB] FAIL %s @%0d: got timeout=%b armed=%b stuck=%0d any=%b, want timeout=%b armed=%b stuck=%0d any=%b",
                             e.name, cyc, io_timeout, io_armed, io_stuck_core, io_timeout_any,
                             e.to, e.armed, e.stuck, |e.to);
                end
            end
        end
    end

    initial begin : stimulus
        reset_n       = 1'b0;
        io_valid      = '0;
        io_limit      = '0;
        io_limit_load = 1'b0;
        io_clear      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset", 0, 2'b00, 2'b00, 2'd0);
        reset_n = 1'b1;

        // Limit 10; core0 commits once, core1 never.
        applyStimulus(2'b00, 1'b1, 16'd10, 1'b0);
        checkOutput("load_idle", 0, 2'b00, 2'b00, 2'd0);
        applyStimulus(2'b01, 1'b0, 16'd0, 1'b0);
        checkOutput("arm_core0", 0, 2'b00, 2'b01, 2'd0);
        checkOutput("pre_timeout0", 10, 2'b00, 2'b01, 2'd0);
        checkOutput("timeout0", 11, 2'b01, 2'b00, 2'd0);
        idleCycles(11);
        applyStimulus(2'b01, 1'b0, 16'd0, 1'b0);
        checkOutput("timeout_sticky", 0, 2'b01, 2'b00, 2'd0);
        applyStimulus(2'b00, 1'b0, 16'd0, 1'b1);
        checkOutput("clear1", 0, 2'b00, 2'b00, 2'd0);

        // Commit every 10 edges never trips; commit at counter 0 rescues;
        // a gap of 11 trips on the edge after the counter reaches 0.
        repeat (3) begin
            applyStimulus(2'b01, 1'b0, 16'd0, 1'b0);
            idleCycles(9);
        end
        checkOutput("periodic", 0, 2'b00, 2'b01, 2'd0);
        applyStimulus(2'b01, 1'b0, 16'd0, 1'b0);
        idleCycles(10);
        checkOutput("count_zero", 0, 2'b00, 2'b01, 2'd0);
        applyStimulus(2'b01, 1'b0, 16'd0, 1'b0);
        checkOutput("valid_at_zero", 0, 2'b00, 2'b01, 2'd0);
        idleCycles(10);
        checkOutput("gap11_pre", 0, 2'b00, 2'b01, 2'd0);
        checkOutput("gap11_timeout", 1, 2'b01, 2'b00, 2'd0);
        idleCycles(1);
        applyStimulus(2'b00, 1'b0, 16'd0, 1'b1);
        checkOutput("clear2", 0, 2'b00, 2'b00, 2'd0);

        // Both cores trip on the same edge.
        applyStimulus(2'b11, 1'b0, 16'd0, 1'b0);
        checkOutput("arm_both", 0, 2'b00, 2'b11, 2'd0);
        idleCycles(10);
        checkOutput("both_pre", 0, 2'b00, 2'b11, 2'd0);
        checkOutput("both_timeout", 1, 2'b11, 2'b00, 2'd0);
        idleCycles(1);
        applyStimulus(2'b00, 1'b0, 16'd0, 1'b1);
        checkOutput("clear_both", 0, 2'b00, 2'b00, 2'd0);

        // Priority encoder: core1 alone, then core0 joins.
        applyStimulus(2'b10, 1'b0, 16'd0, 1'b0);
        idleCycles(11);
        checkOutput("core1_timeout", 0, 2'b10, 2'b00, 2'd1);
        applyStimulus(2'b01, 1'b0, 16'd0, 1'b0);
        checkOutput("core0_arm_core1_stuck", 0, 2'b10, 2'b01, 2'd1);
        idleCycles(11);
        checkOutput("lowest_index", 0, 2'b11, 2'b00, 2'd0);
        applyStimulus(2'b00, 1'b0, 16'd0, 1'b1);

        // Load 5 while core0 counter is at 8: timeout 6 edges after the load.
        applyStimulus(2'b01, 1'b0, 16'd0, 1'b0);
        idleCycles(2);
        applyStimulus(2'b00, 1'b1, 16'd5, 1'b0);
        checkOutput("load5_pre", 5, 2'b00, 2'b01, 2'd0);
        checkOutput("load5_timeout", 6, 2'b01, 2'b00, 2'd0);
        idleCycles(6);
        applyStimulus(2'b00, 1'b0, 16'd0, 1'b1);
        applyStimulus(2'b10, 1'b0, 16'd0, 1'b0);
        checkOutput("limit5_pre", 5, 2'b00, 2'b10, 2'd0);
        checkOutput("limit5_timeout", 6, 2'b10, 2'b00, 2'd1);
        idleCycles(6);
        applyStimulus(2'b00, 1'b0, 16'd0, 1'b1);

        // Limit 0 disables detection; a later load of 3 restarts the window.
        applyStimulus(2'b00, 1'b1, 16'd0, 1'b0);
        applyStimulus(2'b11, 1'b0, 16'd0, 1'b0);
        checkOutput("limit0_mid", 500, 2'b00, 2'b11, 2'd0);
        checkOutput("limit0_end", 1000, 2'b00, 2'b11, 2'd0);
        idleCycles(1000);
        applyStimulus(2'b00, 1'b1, 16'd3, 1'b0);
        checkOutput("load3_pre", 3, 2'b00, 2'b11, 2'd0);
        checkOutput("load3_timeout", 4, 2'b11, 2'b00, 2'd0);
        idleCycles(4);

        // Reset while in TIMEOUT, then default limit in effect.
        reset_n = 1'b0;
        idleCycles(1);
        checkOutput("reset_in_timeout", 0, 2'b00, 2'b00, 2'd0);
        reset_n = 1'b1;
        applyStimulus(2'b01, 1'b0, 16'd0, 1'b0);
        checkOutput("arm_after_reset", 0, 2'b00, 2'b01, 2'd0);
        checkOutput("default_limit_hold", 50, 2'b00, 2'b01, 2'd0);
        idleCycles(52);

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sim_watchdog_mc
